// File: rtl/scanner_buffer.sv
// Per-scanner sample buffer: fills while scanning, drains (xferring) or discards (flushing),
// reports fill level in tenths on prog. Optional macro SCANBUF_DROP_CNT_EN enables drop_cnt.
module scanner_buffer #(
  parameter int DATA_W = 8,
  parameter int WPT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        state,
  input  logic              scan_in_valid,
  input  logic [DATA_W-1:0] scan_in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        prog,
  output logic [7:0]        drop_cnt
);

  localparam int CAP = 10 * WPT;
  localparam int PW  = (CAP > 1) ? $clog2(CAP) : 1;
  localparam int SW  = (WPT > 1) ? $clog2(WPT) : 1;

  localparam logic [2:0] ST_LOWPOWER = 3'b000;
  localparam logic [2:0] ST_SCANNING = 3'b010;
  localparam logic [2:0] ST_XFERRING = 3'b100;
  localparam logic [2:0] ST_FLUSHING = 3'b101;

  logic [DATA_W-1:0] mem [CAP];
  logic [PW-1:0]     wp, rp, wp_e, rp_e, wp_n, rp_n;
  logic [3:0]        t, t_e, t_n, prog_n;
  logic [SW-1:0]     s, s_e, s_n;
  logic [2:0]        prev_state;
  logic              scanning, new_scan, empty, full, push, pop, draining;

  assign scanning = (state == ST_SCANNING);
  assign draining = (state == ST_XFERRING) || (state == ST_FLUSHING);
  assign new_scan = scanning && (prev_state != ST_SCANNING);

  // Entry into scanning clears counters combinationally so a same-cycle sample lands in slot 0.
  always_comb begin
    wp_e = new_scan ? '0 : wp;
    rp_e = new_scan ? '0 : rp;
    t_e  = new_scan ? '0 : t;
    s_e  = new_scan ? '0 : s;
  end

  assign empty     = (t_e == 4'd0) && (s_e == '0);
  assign full      = (t_e == 4'd10);
  assign push      = scanning && scan_in_valid && !full;
  assign out_valid = (state == ST_XFERRING) && !empty;
  assign out_data  = out_valid ? mem[rp] : '0;
  assign pop       = (out_valid && out_ready) || ((state == ST_FLUSHING) && !empty);

  always_comb begin
    wp_n = wp_e;
    rp_n = rp_e;
    t_n  = t_e;
    s_n  = s_e;
    if (push) begin
      wp_n = (wp_e == PW'(CAP - 1)) ? '0 : wp_e + PW'(1);
      if (s_e == SW'(WPT - 1)) begin
        s_n = '0;
        t_n = t_e + 4'd1;
      end else begin
        s_n = s_e + SW'(1);
      end
    end else if (pop) begin
      rp_n = (rp_e == PW'(CAP - 1)) ? '0 : rp_e + PW'(1);
      if (s_e == '0) begin
        s_n = SW'(WPT - 1);
        t_n = t_e - 4'd1;
      end else begin
        s_n = s_e - SW'(1);
      end
    end
    // Draining rounds up so the FSM only sees 0 once the last word has left.
    prog_n = draining ? (t_n + {3'b000, (s_n != '0)}) : t_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      t          <= '0;
      s          <= '0;
      prog       <= '0;
      prev_state <= ST_LOWPOWER;
    end else begin
      wp         <= wp_n;
      rp         <= rp_n;
      t          <= t_n;
      s          <= s_n;
      prog       <= prog_n;
      prev_state <= state;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_e] <= scan_in_data;
  end

`ifdef SCANBUF_DROP_CNT_EN
  logic       drop;
  logic [7:0] drop_q;

  assign drop = scanning && scan_in_valid && full;

  always_ff @(posedge clk) begin
    if (reset || new_scan)
      drop_q <= '0;
    else if (drop && (drop_q != 8'hFF))
      drop_q <= drop_q + 8'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_scanner_buffer.sv
// Self-checking bench for scanner_buffer against a queue-based reference model.
module tb_scanner_buffer;

  localparam int DW  = 8;
  localparam int WPT = 4;
  localparam int CAP = 10 * WPT;

  localparam logic [2:0] S_LOW   = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_IDLE  = 3'd3;
  localparam logic [2:0] S_XFER  = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    state = S_LOW;
  logic          scan_in_valid = 1'b0;
  logic [DW-1:0] scan_in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [3:0]    prog;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue, prog from integer division.
  logic [DW-1:0] mq[$];
  int            m_drops = 0;
  logic [2:0]    m_prev = S_LOW;
  logic [3:0]    m_prog = 4'd0;

  scanner_buffer #(.DATA_W(DW), .WPT(WPT)) dut (
    .clk(clk), .reset(reset), .state(state),
    .scan_in_valid(scan_in_valid), .scan_in_data(scan_in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .prog(prog), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic m_ovalid();
    return (state == S_XFER) && (mq.size() > 0);
  endfunction

  function automatic logic [DW-1:0] m_odata();
    if (m_ovalid()) return mq[0];
    return '0;
  endfunction

  function automatic logic [7:0] m_drop();
`ifdef SCANBUF_DROP_CNT_EN
    return 8'(m_drops);
`else
    return 8'd0;
`endif
  endfunction

  task automatic model_step();
    int n;
    if (reset) begin
      mq.delete();
      m_drops = 0;
      m_prev  = S_LOW;
      m_prog  = 4'd0;
      return;
    end
    if (state == S_SCAN && m_prev != S_SCAN) begin
      mq.delete();
      m_drops = 0;
    end
    if (state == S_SCAN && scan_in_valid) begin
      if (mq.size() < CAP) mq.push_back(scan_in_data);
      else if (m_drops < 255) m_drops++;
    end
    if (mq.size() > 0 && ((state == S_XFER && out_ready) || state == S_FLUSH))
      void'(mq.pop_front());
    m_prev = state;
    n = mq.size();
    if (state == S_XFER || state == S_FLUSH) m_prog = 4'((n + WPT - 1) / WPT);
    else                                     m_prog = 4'(n / WPT);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic go_idle();
    state = S_IDLE; scan_in_valid = 1'b0; out_ready = 1'b0;
    tick();
  endtask

  task automatic fill(input int n, input bit seq);
    state = S_SCAN;
    for (int i = 0; i < n; i++) begin
      scan_in_valid = 1'b1;
      scan_in_data  = seq ? DW'(i) : DW'($urandom);
      tick();
    end
    scan_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; state = S_LOW;
    tick(); tick();
    checks++; if (prog !== 4'd0) begin errors++; $display("FAIL reset_prog: got %0d expected 0", prog); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    state = S_SCAN;
    for (int i = 1; i <= CAP; i++) begin
      scan_in_valid = 1'b1; scan_in_data = DW'($urandom);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_out_valid[%0d]: got %b expected 0", i, out_valid); end
      tick();
      checks++; if (prog !== m_prog) begin errors++; $display("FAIL fill_prog[%0d]: got %0d expected %0d", i, prog, m_prog); end
    end
    checks++; if (prog !== 4'd10) begin errors++; $display("FAIL fill_prog_full: got %0d expected 10", prog); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      scan_in_valid = 1'b1; scan_in_data = DW'($urandom);
      tick();
    end
    scan_in_valid = 1'b0;
    checks++; if (prog !== 4'd10) begin errors++; $display("FAIL ovf_prog: got %0d expected 10", prog); end
`ifdef SCANBUF_DROP_CNT_EN
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 3", drop_cnt); end
`else
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL ovf_drop_cnt: got %0d expected 0", drop_cnt); end
`endif
    // Drain with random backpressure; contents must be the first 40 samples only.
    state = S_XFER;
    for (int c = 0; c < 400 && mq.size() > 0; c++) begin
      out_ready = 1'($urandom);
      #1;
      checks++; if (out_valid !== m_ovalid() || out_data !== m_odata()) begin
        errors++; $display("FAIL ovf_drain[%0d]: got v=%b d=%0h expected v=%b d=%0h", c, out_valid, out_data, m_ovalid(), m_odata());
      end
      tick();
    end
    checks++; if (mq.size() != 0 || prog !== 4'd0) begin errors++; $display("FAIL ovf_drain_end: got prog=%0d left=%0d expected 0/0", prog, mq.size()); end
    go_idle();
  endtask

  task automatic test_transfer();
    int nxt = 0;
    fill(CAP, 1'b1);
    state = S_XFER;
    for (int c = 0; c < 200 && nxt < CAP; c++) begin
      out_ready = (c % 2 == 0);
      #1;
      checks++; if (out_valid !== m_ovalid() || out_data !== m_odata()) begin
        errors++; $display("FAIL xfer_out[%0d]: got v=%b d=%0h expected v=%b d=%0h", c, out_valid, out_data, m_ovalid(), m_odata());
      end
      if (out_ready && out_valid) begin
        checks++; if (out_data !== DW'(nxt)) begin errors++; $display("FAIL xfer_order: got %0d expected %0d", out_data, nxt); end
        nxt++;
      end
      tick();
      checks++; if (prog !== m_prog) begin errors++; $display("FAIL xfer_prog[%0d]: got %0d expected %0d", c, prog, m_prog); end
      if (nxt == 1 && out_ready) begin
        checks++; if (prog !== 4'd10) begin errors++; $display("FAIL xfer_prog_first: got %0d expected 10", prog); end
      end
    end
    checks++; if (nxt != CAP) begin errors++; $display("FAIL xfer_count: got %0d expected %0d", nxt, CAP); end
    checks++; if (prog !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL xfer_end: got prog=%0d v=%b expected 0/0", prog, out_valid); end
    go_idle();
  endtask

  task automatic test_flush();
    fill(6, 1'b0);
    state = S_FLUSH;
    for (int c = 1; c <= 12 && mq.size() > 0; c++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid[%0d]: got %b expected 0", c, out_valid); end
      tick();
      checks++; if (prog !== m_prog) begin errors++; $display("FAIL flush_prog[%0d]: got %0d expected %0d", c, prog, m_prog); end
      if (c == 1) begin
        checks++; if (prog !== 4'd2) begin errors++; $display("FAIL flush_prog_entry: got %0d expected 2", prog); end
      end
      if (c == 2) begin
        checks++; if (prog !== 4'd1) begin errors++; $display("FAIL flush_prog_2pops: got %0d expected 1", prog); end
      end
    end
    checks++; if (prog !== 4'd0) begin errors++; $display("FAIL flush_prog_end: got %0d expected 0", prog); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    fill(CAP, 1'b0);
    state = S_XFER; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    checks++; if (prog !== 4'd5) begin errors++; $display("FAIL rstmid_prog_before: got %0d expected 5", prog); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (prog !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: got prog=%0d v=%b expected 0/0", prog, out_valid); end
    fill(3, 1'b0);
    state = S_XFER;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (out_valid !== m_ovalid() || out_data !== m_odata()) begin
        errors++; $display("FAIL rstmid_fresh[%0d]: got v=%b d=%0h expected v=%b d=%0h", c, out_valid, out_data, m_ovalid(), m_odata());
      end
      tick();
    end
    go_idle();
  endtask

  task automatic test_reentry();
    logic [DW-1:0] w;
    fill(CAP + 2, 1'b0);
    go_idle();
    state = S_FLUSH;
    for (int c = 0; c < 32; c++) tick();
    go_idle();
    checks++; if (prog !== 4'd2 || drop_cnt !== m_drop()) begin errors++; $display("FAIL reentry_held: got prog=%0d drop=%0d expected 2/%0d", prog, drop_cnt, m_drop()); end
    w = DW'($urandom);
    state = S_SCAN; scan_in_valid = 1'b1; scan_in_data = w;
    tick();
    scan_in_valid = 1'b0;
    checks++; if (prog !== 4'd0) begin errors++; $display("FAIL reentry_prog: got %0d expected 0", prog); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reentry_drop: got %0d expected 0", drop_cnt); end
    go_idle();
    state = S_XFER; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== w) begin errors++; $display("FAIL reentry_word: got v=%b d=%0h expected 1/%0h", out_valid, out_data, w); end
    tick();
    #1;
    checks++; if (out_valid !== 1'b0 || prog !== 4'd0) begin errors++; $display("FAIL reentry_empty: got v=%b prog=%0d expected 0/0", out_valid, prog); end
    go_idle();
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        hold  = $urandom_range(1, 60);
        state = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
              : (($urandom_range(0, 1) == 0) ? S_SCAN : S_XFER);
      end
      hold--;
      reset         = ($urandom_range(0, 199) == 0);
      scan_in_valid = 1'($urandom);
      scan_in_data  = DW'($urandom);
      out_ready     = 1'($urandom);
      #1;
      checks++; if (out_valid !== m_ovalid() || out_data !== m_odata()) begin
        errors++; $display("FAIL rand_out[%0d]: got v=%b d=%0h expected v=%b d=%0h", c, out_valid, out_data, m_ovalid(), m_odata());
      end
      tick();
      checks++; if (prog !== m_prog || drop_cnt !== m_drop()) begin
        errors++; $display("FAIL rand_state[%0d]: got prog=%0d drop=%0d expected %0d/%0d", c, prog, drop_cnt, m_prog, m_drop());
      end
    end
    reset = 1'b0;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_transfer();
    test_flush();
    test_reset_mid();
    test_reentry();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
